// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants and types for the multicycle datapath,
//               including the serial compare sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam logic [1:0] SC_IDLE = 2'd0;
  localparam logic [1:0] SC_RUN  = 2'd1;
  localparam logic [1:0] SC_FIN  = 2'd2;

  localparam int CMP_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = SC_IDLE,
    ST_RUN  = SC_RUN,
    ST_FIN  = SC_FIN
  } sc_state_t;

endpackage
`default_nettype wire

// File: rtl/comparator1x2.sv
`default_nettype none
// ============================================================================
// Module      : comparator1x2
// Description : One-bit cascadable magnitude compare step. Once an upstream
//               (more significant) decision exists on lti/gti it is passed
//               through; otherwise the local bit pair decides.
// Revision    : 1.0 - initial release
// ============================================================================
module comparator1x2 (
  input  logic a,
  input  logic b,
  input  logic lti,
  input  logic gti,
  output logic lt,
  output logic gt
);

  assign lt = lti | (~gti & ~a &  b);
  assign gt = gti | (~lti &  a & ~b);

endmodule
`default_nettype wire

// File: rtl/serial_compare_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_compare_ctrl
// Description : Bit-serial magnitude compare sequencer. Streams the operands
//               MSB-first through a single comparator1x2 cell, feeding its
//               decision back as cascade input, and holds the lt/eq/gt result
//               until the next accepted request.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_compare_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int CW = $clog2(WIDTH);
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] C_MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  sc_state_t        r_state;
  sc_state_t        w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CW-1:0]    r_cnt;
  logic             r_flt;
  logic             r_fgt;
  logic             r_done;
  logic             r_lt;
  logic             r_eq;
  logic             r_gt;
  logic             w_cell_lt;
  logic             w_cell_gt;
  logic             w_busy;

  comparator1x2 u_cmp (
    .a   (r_sa[WIDTH-1]),
    .b   (r_sb[WIDTH-1]),
    .lti (r_flt),
    .gti (r_fgt),
    .lt  (w_cell_lt),
    .gt  (w_cell_gt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and busy decode; RUN exits early once the cell has decided.
  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (w_cell_lt || w_cell_gt || (r_cnt == '0)) begin
          w_next = ST_FIN;
        end
      end
      ST_FIN: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Operand shift registers, bit counter, decision flags and held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_cnt  <= '0;
      r_flt  <= 1'b0;
      r_fgt  <= 1'b0;
      r_done <= 1'b0;
      r_lt   <= 1'b0;
      r_eq   <= 1'b0;
      r_gt   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sa  <= is_signed ? (a ^ C_MSB_MASK) : a;
            r_sb  <= is_signed ? (b ^ C_MSB_MASK) : b;
            r_cnt <= CW'(WIDTH-1);
            r_flt <= 1'b0;
            r_fgt <= 1'b0;
            r_lt  <= 1'b0;
            r_eq  <= 1'b0;
            r_gt  <= 1'b0;
          end
        end
        ST_RUN: begin
          r_flt <= w_cell_lt;
          r_fgt <= w_cell_gt;
          r_sa  <= r_sa << 1;
          r_sb  <= r_sb << 1;
          r_cnt <= r_cnt - 1'b1;
        end
        ST_FIN: begin
          r_lt   <= r_flt;
          r_gt   <= r_fgt;
          r_eq   <= ~r_flt & ~r_fgt;
          r_done <= 1'b1;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign busy = w_busy;
  assign done = r_done;
  assign lt   = r_lt;
  assign eq   = r_eq;
  assign gt   = r_gt;

endmodule
`default_nettype wire

// File: tb/tb_serial_compare_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_compare_ctrl
// Description : Directed self-checking bench for serial_compare_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_compare_ctrl;

  localparam logic [2:0] C_LT = 3'b100;
  localparam logic [2:0] C_EQ = 3'b010;
  localparam logic [2:0] C_GT = 3'b001;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        lt;
  logic        eq;
  logic        gt;

  int n_checks;
  int n_errors;

  serial_compare_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .lt        (lt),
    .eq        (eq),
    .gt        (gt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One request: start is driven in the first cycle; latency counts cycles
  // from the start cycle to the cycle where done is seen.
  task automatic do_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                       input logic is, input logic [2:0] exp_res, input int exp_lat,
                       input int exp_busy, input bit chk_hold, input logic [2:0] hold,
                       input int inject_at);
    int  lat;
    int  busyc;
    bit  got;
    @(negedge clk);
    if (chk_hold) begin
      check({tag, " hold"}, {29'd0, lt, eq, gt}, {29'd0, hold});
      check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    end
    a = ia; b = ib; is_signed = is; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~ia; b = ~ib; is_signed = ~is;
    lat = 1; busyc = 0; got = 1'b0;
    check({tag, " clr"}, {29'd0, lt, eq, gt}, 32'd0);
    while (lat < 80) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) busyc++;
      if (lat == inject_at) begin
        start = 1'b1; a = 32'h0; b = 32'hFFFF_FFFF; is_signed = 1'b0;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    check({tag, " done_seen"}, {31'd0, got}, 32'd1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy_cycles"}, busyc, exp_busy);
    check({tag, " result"}, {29'd0, lt, eq, gt}, {29'd0, exp_res});
  endtask

  initial begin
    int dcount;
    int bcount;
    n_checks = 0; n_errors = 0;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset outs", {27'd0, busy, done, lt, eq, gt}, 32'd0);
    reset = 1'b0;

    // Reset mid-RUN with equal operands, held two cycles.
    @(negedge clk);
    start = 1'b1; a = 32'h0; b = 32'h0; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("midrun busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst1 outs", {27'd0, busy, done, lt, eq, gt}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0; bcount = 0;
    repeat (40) begin
      if (done) dcount++;
      if (busy) bcount++;
      @(negedge clk);
    end
    check("rst no done", dcount, 0);
    check("rst no busy", bcount, 0);

    // Reset dominates a simultaneous start.
    reset = 1'b1; start = 1'b1; a = 32'h1; b = 32'h2;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_vs_start busy", {31'd0, busy}, 32'd0);

    do_op("u_msb",   32'h8000_0000, 32'h7FFF_FFFF, 1'b0, C_GT, 3,  1,  1'b0, 3'b000, -1);
    do_op("s_msb",   32'h8000_0000, 32'h7FFF_FFFF, 1'b1, C_LT, 3,  1,  1'b0, 3'b000, -1);
    do_op("eq_u",    32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, C_EQ, 34, 32, 1'b0, 3'b000, -1);
    do_op("eq_s",    32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, C_EQ, 34, 32, 1'b0, 3'b000, -1);
    do_op("lsb",     32'h0000_0004, 32'h0000_0005, 1'b0, C_LT, 34, 32, 1'b0, 3'b000, 5);
    do_op("mid",     32'h1234_5678, 32'h1234_0678, 1'b0, C_GT, 20, 18, 1'b0, 3'b000, -1);
    // Back-to-back: second start in the cycle right after the first done.
    do_op("b2b_1",   32'h8000_0000, 32'h7FFF_FFFF, 1'b0, C_GT, 3,  1,  1'b0, 3'b000, -1);
    do_op("b2b_2",   32'hFFFF_FFFF, 32'h0000_0001, 1'b1, C_LT, 3,  1,  1'b1, C_GT,   -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_compare_ctrl.md
# serial_compare_ctrl

Bit-serial magnitude-comparison sequencer for the multicycle datapath. It time-shares one existing `comparator1x2` cell across a full operand, presenting one bit pair per cycle from MSB to LSB and feeding the cell's `lt`/`gt` outputs back as its cascade inputs. It serves `slt`/`sltu`/`slti`/`sltiu` and compare-style branches when the control unit selects the low-area compare path. Results are held stable for the control FSM until the next accepted request.

## Interface
- `WIDTH`, default 32: operand width in bits; must be ≥ 2.
- `clk`  in  1  : single clock; all state updates on the rising edge.
- `reset`  in  1  : synchronous, active-high; sampled on the rising edge of `clk`.
- `start`  in  1  : request pulse; accepted only in IDLE.
- `is_signed`  in  1  : 1 = two's-complement compare, 0 = unsigned; sampled with `start`.
- `a`  in  WIDTH  : operand A; sampled with `start`.
- `b`  in  WIDTH  : operand B; sampled with `start`.
- `busy`  out  1  : high in RUN.
- `done`  out  1  : one-cycle pulse when the result becomes valid.
- `lt`  out  1  : A < B; registered, held until next accepted start.
- `eq`  out  1  : A == B; same hold rule.
- `gt`  out  1  : A > B; same hold rule.

## Operation
- States: IDLE, RUN, FIN.
- **IDLE**
  - `start=1`: load the shift registers as `sa <= a`, `sb <= b`.
  - If `is_signed`, invert the MSB of both loaded values. This maps signed order onto unsigned order.
  - Clear flag registers `flt`, `fgt` and the outputs `lt`/`eq`/`gt`.
  - Load the bit counter with `WIDTH-1`; go to RUN.
- **RUN**
  - Drive the cell with `a = sa[WIDTH-1]`, `b = sb[WIDTH-1]`, `lti = flt`, `gti = fgt`.
  - Each cycle: register the cell outputs into `flt`/`fgt`, shift `sa`/`sb` left by 1 (zero fill), decrement the counter.
  - Go to FIN when the cell's `lt` or `gt` output is 1 (early exit), or when the counter is 0.
- **FIN**
  - Copy the flags to the outputs: `lt = flt`, `gt = fgt`, `eq = ~flt & ~fgt`.
  - Pulse `done`; return to IDLE.
- Exactly one of `lt`/`eq`/`gt` is high after any `done`. All three are 0 between an accepted start and its `done`.
- `start` in RUN or FIN is ignored, not queued.
- Operand or `is_signed` changes after acceptance have no effect.
- Counter width is `$clog2(WIDTH)`.

## Timing
- Reset values: state IDLE; `busy`, `done`, `lt`, `eq`, `gt` all 0; `flt`, `fgt`, `sa`, `sb` and the counter all 0.
- Start accepted at edge t: RUN spans edges t+1 … t+k; FIN at edge t+k+1.
- `done` and the new result are visible in the cycle after edge t+k+1.
- k = 1 + (index from MSB of the first differing bit, after the MSB transform), or k = WIDTH when the operands are equal.
- Latency range:
  - Minimum (MSBs differ): `done` is visible 3 cycles after the start cycle.
  - Maximum (equal operands, WIDTH=32): 34 cycles.
- Back-to-back: the earliest next accepted start is the cycle after the `done` cycle (IDLE).
- Reset while in RUN or FIN: IDLE on the next edge, no `done`, outputs cleared. Reset dominates a simultaneous `start`.

## Structure
- Shared package `cpu_pkg`:
  - State encoding localparams `SC_IDLE=2'd0`, `SC_RUN=2'd1`, `SC_FIN=2'd2`.
  - Default `CMP_WIDTH=32`.
- One sub-module instance: `comparator1x2` (existing cell), used unmodified as the per-bit compare step.
- Sequential logic in this block:
  - State register and next-state logic.
  - Counter.
  - Two WIDTH-bit shift registers.
  - Flag registers and result registers.

## Test plan
- **Reset:** hold `reset` for 2 cycles mid-RUN (`a=0`, `b=0`, `is_signed=0`) → IDLE on the next edge, no `done` pulse, all outputs 0, `busy`=0.
- **Unsigned MSB difference:** `a=32'h8000_0000`, `b=32'h7FFF_FFFF`, `is_signed=0` → `gt=1`; `done` 3 cycles after the start cycle (one RUN cycle).
- **Signed MSB difference:** same operands, `is_signed=1` → `lt=1` (−2^31 < 2^31−1); latency 3 cycles.
- **Equal operands:** `a=b=32'hDEAD_BEEF`, either signedness → `eq=1`; exactly 32 `busy` cycles; `done` 34 cycles after start.
- **LSB-only difference:** `a=32'h0000_0004`, `b=32'h0000_0005`, unsigned → `lt=1` after 32 RUN cycles. A `start` pulsed with other operands mid-RUN is ignored.
- **Back-to-back:** two requests, with the second `start` asserted the cycle after the first `done` (`a=32'hFFFF_FFFF`, `b=1`, signed) → second result `lt=1`; the first result is held unchanged until the second start is accepted.
